// File: rtl/video_port_ctl.sv
// video_port_ctl: CPU I/O-port front end for the video scanout block.
// Owns the video mode bit and the hardware cursor, and sequences VGA-style
// DAC palette accesses (3C7/3C8/3C9). 6-bit RGB components go in and out on
// the CPU side, and the palette RAM holds 4 bits per channel.
module video_port_ctl #(
    parameter logic [11:0] CURSOR_INIT = 12'd0,
    parameter logic        MODE_INIT   = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] port_a,
    input  logic [7:0]  port_i,
    input  logic        port_w,
    input  logic        port_r,
    output logic [7:0]  port_o,
    output logic        port_ack,
    output logic        videomode,
    output logic [11:0] cursor,
    output logic [7:0]  dac_wa,
    output logic [11:0] dac_wd,
    output logic        dac_we,
    output logic [7:0]  dac_ra,
    input  logic [11:0] dac_rq
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, ACK} state_t;

    // Read result captured at sampling time and presented when the ack arrives.
    // A 3C9 read that crosses a triple boundary must return the B value from
    // the old latch, even though the prefetch overwrites the latch first.
    typedef struct packed {
        logic       rd;
        logic [7:0] val;
    } pend_t;

    state_t      state, state_nx;
    pend_t       pend;

    logic [7:0]  widx, ridx, dac_state, crtc_idx;
    logic [1:0]  wsub, rsub;
    logic [7:0]  wr_rg;      // R and G nibbles of the triple being written
    logic [11:0] rd_latch;   // palette entry being read out

    logic        sel_3c7, sel_3c8, sel_3c9, sel_3d4, sel_3d5, sel_3d8, claimed;
    logic        do_wr, do_rd, start, prefetch;
    logic [3:0]  rd_nib;
    logic [7:0]  rd_val, ridx_nx;

    // Port decode. When both requests are high, the write takes priority.
    assign sel_3c7  = (port_a == 16'h03C7);
    assign sel_3c8  = (port_a == 16'h03C8);
    assign sel_3c9  = (port_a == 16'h03C9);
    assign sel_3d4  = (port_a == 16'h03D4);
    assign sel_3d5  = (port_a == 16'h03D5);
    assign sel_3d8  = (port_a == 16'h03D8);
    assign claimed  = sel_3c7 | sel_3c8 | sel_3c9 | sel_3d4 | sel_3d5 | sel_3d8;
    assign do_wr    = port_w;
    assign do_rd    = port_r & ~port_w;
    assign start    = (state == IDLE) & claimed & (port_w | port_r);
    assign prefetch = start & ((do_wr & sel_3c7) | (do_rd & sel_3c9 & (rsub == 2'd2)));
    assign ridx_nx  = sel_3c7 ? port_i : ridx + 8'd1;

    // Read-data mux. A palette nibble is widened to 6 bits by replicating its MSBs.
    always_comb begin
        rd_val = 8'h00;
        case (rsub)
            2'd0:    rd_nib = rd_latch[11:8];
            2'd1:    rd_nib = rd_latch[7:4];
            default: rd_nib = rd_latch[3:0];
        endcase
        if (sel_3c8)      rd_val = widx;
        else if (sel_3c7) rd_val = dac_state;
        else if (sel_3c9) rd_val = {2'b00, rd_nib, rd_nib[3:2]};
        else if (sel_3d4) rd_val = crtc_idx;
        else if (sel_3d5) begin
            if (crtc_idx == 8'h0E)      rd_val = {4'h0, cursor[11:8]};
            else if (crtc_idx == 8'h0F) rd_val = cursor[7:0];
        end
        else if (sel_3d8) rd_val = {7'b0, videomode};
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state. Plain accesses ack directly, and palette prefetches detour through the RAM.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = prefetch ? FETCH : ACK;
            FETCH:   state_nx = LATCH;
            LATCH:   state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Register file, palette sequencing and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            port_o    <= 8'h00;
            port_ack  <= 1'b0;
            videomode <= MODE_INIT;
            cursor    <= CURSOR_INIT;
            dac_wa    <= 8'h00;
            dac_wd    <= 12'h000;
            dac_we    <= 1'b0;
            dac_ra    <= 8'h00;
            widx      <= 8'h00;
            ridx      <= 8'h00;
            wsub      <= 2'd0;
            rsub      <= 2'd0;
            dac_state <= 8'h00;
            crtc_idx  <= 8'h00;
            wr_rg     <= 8'h00;
            rd_latch  <= 12'h000;
            pend      <= '0;
        end else begin
            port_ack <= 1'b0;
            dac_we   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pend.rd  <= do_rd;
                    pend.val <= rd_val;
                    if (prefetch) begin
                        dac_ra <= ridx_nx;
                    end else begin
                        port_ack <= 1'b1;
                        if (do_rd) port_o <= rd_val;
                    end
                    if (do_wr) begin
                        if (sel_3c8) begin
                            widx      <= port_i;
                            wsub      <= 2'd0;
                            dac_state <= 8'h00;
                        end
                        if (sel_3c7) begin
                            ridx      <= port_i;
                            rsub      <= 2'd0;
                            dac_state <= 8'h03;
                        end
                        if (sel_3c9) begin
                            case (wsub)
                                2'd0: begin
                                    wr_rg[7:4] <= port_i[5:2];
                                    wsub       <= 2'd1;
                                end
                                2'd1: begin
                                    wr_rg[3:0] <= port_i[5:2];
                                    wsub       <= 2'd2;
                                end
                                default: begin
                                    dac_we <= 1'b1;
                                    dac_wa <= widx;
                                    dac_wd <= {wr_rg, port_i[5:2]};
                                    widx   <= widx + 8'd1;
                                    wsub   <= 2'd0;
                                end
                            endcase
                        end
                        if (sel_3d4) crtc_idx <= port_i;
                        if (sel_3d5) begin
                            if (crtc_idx == 8'h0E)      cursor[11:8] <= port_i[3:0];
                            else if (crtc_idx == 8'h0F) cursor[7:0]  <= port_i;
                        end
                        if (sel_3d8) videomode <= port_i[0];
                    end else if (sel_3c9) begin
                        if (rsub == 2'd2) begin
                            ridx <= ridx + 8'd1;
                            rsub <= 2'd0;
                        end else begin
                            rsub <= rsub + 2'd1;
                        end
                    end
                end
                // RAM data for dac_ra shows up this cycle, so capture it and ack.
                LATCH: begin
                    rd_latch <= dac_rq;
                    port_ack <= 1'b1;
                    if (pend.rd) port_o <= pend.val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_video_port_ctl.sv
// Directed bench for video_port_ctl with a registered palette ROM model and
// scoreboards for read data and palette writes.
module tb_video_port_ctl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] port_a;
    logic [7:0]  port_i;
    logic        port_w, port_r;
    logic [7:0]  port_o;
    logic        port_ack;
    logic        videomode;
    logic [11:0] cursor;
    logic [7:0]  dac_wa;
    logic [11:0] dac_wd;
    logic        dac_we;
    logic [7:0]  dac_ra;
    logic [11:0] dac_rq = 12'h000;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  rd_sb[$];     // expected read data
    logic [19:0] we_sb[$];     // expected {dac_wa, dac_wd}

    int          we_cnt = 0;   // palette write pulses seen
    int          we_bad = 0;   // dac_we seen without port_ack
    logic [19:0] we_last = '0;
    logic [7:0]  fetch_ra;

    video_port_ctl #(.CURSOR_INIT(12'h123), .MODE_INIT(1'b0)) dut (
        .clock(clock), .reset_n(reset_n),
        .port_a(port_a), .port_i(port_i), .port_w(port_w), .port_r(port_r),
        .port_o(port_o), .port_ack(port_ack),
        .videomode(videomode), .cursor(cursor),
        .dac_wa(dac_wa), .dac_wd(dac_wd), .dac_we(dac_we),
        .dac_ra(dac_ra), .dac_rq(dac_rq)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] rom(input logic [7:0] a);
        case (a)
            8'h05:   return 12'hF0A;
            8'h06:   return 12'h5C3;
            default: return {4'h0, a};
        endcase
    endfunction

    // Registered palette RAM with one cycle of latency.
    always @(posedge clock) dac_rq <= rom(dac_ra);

    // Palette write monitor.
    always @(negedge clock) begin
        if (reset_n && dac_we) begin
            we_cnt  <= we_cnt + 1;
            we_last <= {dac_wa, dac_wd};
            if (!port_ack) we_bad <= we_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One handshake: hold the request until ack, then check latency, data and pulse width.
    task automatic xfer(input logic w, input logic r, input logic [15:0] a,
                        input logic [7:0] d, input int lat, input string tag);
        int n;
        logic [7:0] exp;
        n = 0;
        port_a = a; port_i = d; port_w = w; port_r = r;
        fetch_ra = 8'hxx;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) fetch_ra = dac_ra;
        end while (!port_ack && n < 20);
        port_w = 1'b0; port_r = 1'b0;
        chk({tag, ".lat"}, n, lat);
        if (r && !w) begin
            exp = rd_sb.pop_front();
            chk({tag, ".data"}, {24'h0, port_o}, {24'h0, exp});
        end
        @(negedge clock);
        chk({tag, ".pulse"}, {31'h0, port_ack}, 32'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int lat, input string tag);
        xfer(1'b1, 1'b0, a, d, lat, tag);
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input int lat, input string tag);
        rd_sb.push_back(exp);
        xfer(1'b0, 1'b1, a, 8'h00, lat, tag);
    endtask

    // Compare the next palette write pulse against the scoreboard.
    task automatic chk_we(input int cnt_exp, input string tag);
        logic [19:0] exp;
        exp = we_sb.pop_front();
        chk({tag, ".we_cnt"}, we_cnt, cnt_exp);
        chk({tag, ".we"}, {12'h0, we_last}, {12'h0, exp});
    endtask

    initial begin
        int acks;
        reset_n = 1'b0;
        port_a = 16'h0; port_i = 8'h0; port_w = 1'b0; port_r = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst.cursor", {20'h0, cursor}, 32'h123);
        chk("rst.mode",   {31'h0, videomode}, 32'h0);
        chk("rst.ack",    {31'h0, port_ack}, 32'h0);
        chk("rst.we",     {31'h0, dac_we}, 32'h0);
        chk("rst.port_o", {24'h0, port_o}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        rd(16'h03C7, 8'h00, 1, "rst.3c7");

        // Palette write of one triple.
        wr(16'h03C8, 8'h10, 1, "pw.idx");
        we_sb.push_back({8'h10, 12'hF0A});
        wr(16'h03C9, 8'h3F, 1, "pw.r");
        wr(16'h03C9, 8'h00, 1, "pw.g");
        chk("pw.no_early_we", we_cnt, 0);
        wr(16'h03C9, 8'h2A, 1, "pw.b");
        chk_we(1, "pw");
        rd(16'h03C8, 8'h11, 1, "pw.idx_rb");

        // Write index wraps from FF to 00.
        wr(16'h03C8, 8'hFF, 1, "wrap.idx");
        we_sb.push_back({8'hFF, 12'h123});
        wr(16'h03C9, 8'h04, 1, "wrap.r0");
        wr(16'h03C9, 8'h08, 1, "wrap.g0");
        wr(16'h03C9, 8'h0C, 1, "wrap.b0");
        chk_we(2, "wrap0");
        we_sb.push_back({8'h00, 12'h456});
        wr(16'h03C9, 8'h10, 1, "wrap.r1");
        wr(16'h03C9, 8'h14, 1, "wrap.g1");
        wr(16'h03C9, 8'h18, 1, "wrap.b1");
        chk_we(3, "wrap1");
        rd(16'h03C8, 8'h01, 1, "wrap.idx_rb");

        // Palette read with prefetch.
        wr(16'h03C7, 8'h05, 3, "pr.idx");
        chk("pr.fetch_ra", {24'h0, fetch_ra}, 32'h05);
        rd(16'h03C9, 8'h3F, 1, "pr.r");
        rd(16'h03C9, 8'h00, 1, "pr.g");
        rd(16'h03C9, 8'h2A, 3, "pr.b");
        chk("pr.fetch_ra2", {24'h0, fetch_ra}, 32'h06);
        rd(16'h03C7, 8'h03, 1, "pr.state");
        rd(16'h03C9, 8'h15, 1, "pr.next_r");
        rd(16'h03C8, 8'h01, 1, "pr.widx_indep");

        // Cursor and mode registers.
        wr(16'h03D4, 8'h0E, 1, "cur.ix_hi");
        wr(16'h03D5, 8'h1A, 1, "cur.hi");
        wr(16'h03D4, 8'h0F, 1, "cur.ix_lo");
        wr(16'h03D5, 8'h34, 1, "cur.lo");
        chk("cur.val", {20'h0, cursor}, 32'hA34);
        rd(16'h03D5, 8'h34, 1, "cur.rd_lo");
        wr(16'h03D4, 8'h0E, 1, "cur.ix_hi2");
        rd(16'h03D5, 8'h0A, 1, "cur.rd_hi");
        wr(16'h03D4, 8'h0A, 1, "cur.ix_other");
        wr(16'h03D5, 8'h77, 1, "cur.wr_other");
        chk("cur.unchanged", {20'h0, cursor}, 32'hA34);
        rd(16'h03D5, 8'h00, 1, "cur.rd_other");
        rd(16'h03D4, 8'h0A, 1, "cur.rd_idx");
        wr(16'h03D8, 8'h01, 1, "mode.wr");
        chk("mode.val", {31'h0, videomode}, 32'h1);
        rd(16'h03D8, 8'h01, 1, "mode.rd");

        // Write and read both high: only the write is performed.
        xfer(1'b1, 1'b1, 16'h03D8, 8'h00, 1, "both");
        chk("both.mode", {31'h0, videomode}, 32'h0);
        chk("both.port_o", {24'h0, port_o}, 32'h01);

        // Unclaimed port: no ack.
        acks = 0;
        port_a = 16'h0060; port_i = 8'h55; port_w = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (port_ack) acks++;
        end
        port_w = 1'b0;
        chk("unclaimed.acks", acks, 0);

        // Reset during FETCH aborts the access.
        port_a = 16'h03C7; port_i = 8'h07; port_w = 1'b1;
        @(negedge clock);
        chk("abort.fetch_ra", {24'h0, dac_ra}, 32'h07);
        reset_n = 1'b0;
        @(negedge clock);
        port_w = 1'b0;
        reset_n = 1'b1;
        acks = 0;
        repeat (5) begin
            if (port_ack) acks++;
            @(negedge clock);
        end
        chk("abort.acks", acks, 0);
        chk("abort.cursor", {20'h0, cursor}, 32'h123);
        rd(16'h03C7, 8'h00, 1, "abort.state");
        rd(16'h03C8, 8'h00, 1, "abort.widx");

        chk("we.total", we_cnt, 3);
        chk("we.outside_ack", we_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
